// File: rtl/spi_target_if.sv
// Parallel-side bus of the SPI target: TX holding-register handshake, RX strobe and status.
interface spi_target_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  // master = local agent feeding TX / consuming RX; slave = the SPI target itself
  modport master (output tx_data, tx_valid,
                  input  tx_ready, rx_data, rx_valid, tx_underrun, busy);
  modport slave  (input  tx_data, tx_valid,
                  output tx_ready, rx_data, rx_valid, tx_underrun, busy);
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, byte oriented. All pins are oversampled in the HCLK domain;
// a one-byte TX holding register and an RX strobe form the parallel side.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic SCLK_i,
  input  logic SSn_i,
  input  logic MOSI_i,
  output logic MISO_o,
  output logic MISO_oe,
  spi_target_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, ssn_sync_q, mosi_sync_q;
  logic                   sclk_d1_q, ssn_d1_q;
  logic [2:0]             cnt_q;
  logic [7:0]             shift_tx_q, shift_rx_q, rx_data_q, hold_q;
  logic                   hold_full_q, rx_valid_q, underrun_q;
  logic                   sclk_s, ssn_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ssn_fall, ssn_rise;
  logic [7:0]             load_byte;
  logic                   consume;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ssn_sync_q  <= '1;
      sclk_d1_q   <= 1'b0;
      ssn_d1_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_i};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], SSn_i};
      sclk_d1_q   <= sclk_s;
      ssn_d1_q    <= ssn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s &  sclk_d1_q;
  assign ssn_fall  = ~ssn_s  &  ssn_d1_q;
  assign ssn_rise  =  ssn_s  & ~ssn_d1_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ssn_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (ssn_fall) state_d = LOAD;
        LOAD:    state_d = SHIFT;
        SHIFT:   if (sclk_rise && cnt_q == 3'd7) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // The MSB of the byte being loaded goes straight to the pin so the first bit
  // is already valid in the LOAD cycle.
  always_comb begin
    load_byte = hold_full_q ? hold_q : DUMMY_BYTE;
    consume   = (state_q == LOAD) && hold_full_q && !ssn_rise;
    MISO_o    = (state_q == LOAD) ? load_byte[7] : shift_tx_q[7];
    MISO_oe   = ~ssn_s;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q      <= 3'd0;
      shift_tx_q <= 8'h00;
      shift_rx_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (ssn_rise) begin
        // deselect drops any partial byte in both directions
        cnt_q      <= 3'd0;
        shift_tx_q <= 8'h00;
        shift_rx_q <= 8'h00;
      end else begin
        case (state_q)
          IDLE: cnt_q <= 3'd0;
          LOAD: begin
            shift_tx_q <= load_byte;
            underrun_q <= ~hold_full_q;
          end
          SHIFT: begin
            if (sclk_rise) begin
              shift_rx_q <= {shift_rx_q[6:0], mosi_s};
              cnt_q      <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                rx_data_q  <= {shift_rx_q[6:0], mosi_s};
                rx_valid_q <= 1'b1;
              end
            end else if (sclk_fall && cnt_q != 3'd0) begin
              shift_tx_q <= {shift_tx_q[6:0], 1'b0};
            end
          end
          default: cnt_q <= 3'd0;
        endcase
      end
    end
  end

  // tx_ready gates the load, so a load and a consume never hit the same cycle
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (bus.tx_valid && !hold_full_q) begin
      hold_q      <= bus.tx_data;
      hold_full_q <= 1'b1;
    end else if (consume) begin
      hold_full_q <= 1'b0;
    end
  end

  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.busy        = ~ssn_s;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: SPI master with SCLK period 8 HCLK, agent on the parallel side.
module tb_spi_target;
  logic clk = 1'b0, rst = 1'b1;
  logic sclk = 1'b0, ssn = 1'b1, mosi = 1'b0;
  logic miso, miso_oe;
  int   errors = 0, checks = 0;
  int   rxv_cnt = 0, und_cnt = 0;
  int   base_rv, base_un;
  logic [7:0] rxlog[$];
  logic [7:0] mi, mi0, mi1, mi2;

  spi_target_if bus();

  spi_target #(.SYNC_STAGES(2), .DUMMY_BYTE(8'hFF)) dut (
    .HCLK(clk), .HRESET(rst), .SCLK_i(sclk), .SSn_i(ssn), .MOSI_i(mosi),
    .MISO_o(miso), .MISO_oe(miso_oe), .bus(bus)
  );

  always #5 clk = ~clk;

  // strobe monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (bus.rx_valid) begin
      rxv_cnt++;
      rxlog.push_back(bus.rx_data);
    end
    if (bus.tx_underrun) und_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    while (!bus.tx_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("push_ready", {31'd0, bus.tx_ready}, 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic spi_select();
    @(negedge clk);
    ssn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_deselect();
    repeat (4) @(negedge clk);
    ssn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_shift(input logic [7:0] mo, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      r = {r[6:0], miso};
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic wait_rxv(input int target);
    for (int k = 0; k < 2000 && rxv_cnt < target; k++) @(negedge clk);
    check("wait_rx_valid", {31'd0, rxv_cnt >= target}, 32'd1);
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_miso_oe",  {31'd0, miso_oe}, 32'd0);
    check("rst_busy",     {31'd0, bus.busy}, 32'd0);
    check("rst_miso",     {31'd0, miso}, 32'd0);
    check("rst_rx_data",  {24'd0, bus.rx_data}, 32'h00);
    repeat (100) @(negedge clk);
    check("idle_rx_valid_cnt", rxv_cnt, 0);
    check("idle_underrun_cnt", und_cnt, 0);

    // single byte with preload
    base_rv = rxv_cnt; base_un = und_cnt;
    push(8'hA5);
    check("preload_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
    spi_select();
    check("sel_busy",    {31'd0, bus.busy}, 32'd1);
    check("sel_miso_oe", {31'd0, miso_oe}, 32'd1);
    spi_shift(8'h3C, 8, mi);
    spi_deselect();
    check("single_miso",    {24'd0, mi}, 32'hA5);
    check("single_rxv_cnt", rxv_cnt - base_rv, 1);
    check("single_rx_data", {24'd0, bus.rx_data}, 32'h3C);
    check("single_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    // the reload right after bit 7 finds the hold empty
    check("single_underrun", und_cnt - base_un, 1);

    // underrun at select; a filler byte covers the reload after bit 7
    base_rv = rxv_cnt; base_un = und_cnt;
    fork
      begin
        spi_select();
        spi_shift(8'h00, 8, mi);
        spi_deselect();
      end
      begin
        for (int k = 0; k < 200 && und_cnt == base_un; k++) @(negedge clk);
        push(8'h55);
      end
    join
    check("under_miso",    {24'd0, mi}, 32'hFF);
    check("under_cnt",     und_cnt - base_un, 1);
    check("under_rx_data", {24'd0, bus.rx_data}, 32'h00);
    check("under_rxv_cnt", rxv_cnt - base_rv, 1);

    // three-byte burst, agent keeps the hold one byte ahead
    base_rv = rxv_cnt; base_un = und_cnt;
    push(8'h10);
    fork
      begin
        spi_select();
        spi_shift(8'h01, 8, mi0);
        spi_shift(8'h02, 8, mi1);
        spi_shift(8'h03, 8, mi2);
        spi_deselect();
      end
      begin
        push(8'h20);
        wait_rxv(base_rv + 1);
        push(8'h30);
        wait_rxv(base_rv + 2);
        push(8'h40);
      end
    join
    check("burst_miso0", {24'd0, mi0}, 32'h10);
    check("burst_miso1", {24'd0, mi1}, 32'h20);
    check("burst_miso2", {24'd0, mi2}, 32'h30);
    check("burst_rxv_cnt", rxv_cnt - base_rv, 3);
    check("burst_rx0", {24'd0, rxlog[rxlog.size()-3]}, 32'h01);
    check("burst_rx1", {24'd0, rxlog[rxlog.size()-2]}, 32'h02);
    check("burst_rx2", {24'd0, rxlog[rxlog.size()-1]}, 32'h03);
    check("burst_underrun", und_cnt - base_un, 0);

    // abort after 5 bits, then a clean transfer
    base_rv = rxv_cnt;
    spi_select();
    spi_shift(8'hFF, 5, mi);
    spi_deselect();
    check("abort_rxv_cnt", rxv_cnt - base_rv, 0);
    check("abort_busy",    {31'd0, bus.busy}, 32'd0);
    check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("abort_rx_data", {24'd0, bus.rx_data}, 32'h03);
    push(8'h5A);
    spi_select();
    spi_shift(8'hC3, 8, mi);
    spi_deselect();
    check("post_abort_miso",    {24'd0, mi}, 32'h5A);
    check("post_abort_rx_data", {24'd0, bus.rx_data}, 32'hC3);
    check("post_abort_rxv_cnt", rxv_cnt - base_rv, 1);

    // asynchronous reset after 3 bits
    push(8'h96);
    spi_select();
    spi_shift(8'hF0, 3, mi);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("arst_miso_oe",  {31'd0, miso_oe}, 32'd0);
    check("arst_busy",     {31'd0, bus.busy}, 32'd0);
    check("arst_miso",     {31'd0, miso}, 32'd0);
    check("arst_rx_data",  {24'd0, bus.rx_data}, 32'h00);
    check("arst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("arst_underrun", {31'd0, bus.tx_underrun}, 32'd0);
    ssn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    base_rv = rxv_cnt;
    push(8'h3E);
    spi_select();
    spi_shift(8'h81, 8, mi);
    spi_deselect();
    check("post_rst_miso",    {24'd0, mi}, 32'h3E);
    check("post_rst_rx_data", {24'd0, bus.rx_data}, 32'h81);
    check("post_rst_rxv_cnt", rxv_cnt - base_rv, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
